// File: rtl/rv_decode_stage.sv
// rv_decode_stage
//   RV32I decode stage between fetch and execute. Classifies one instruction
//   per transfer, extracts register indices, funct fields and the
//   sign-extended immediate, flags illegal encodings, and registers the result
//   behind a valid/stall handshake. An optional one-entry skid buffer makes
//   o_ready a flop.
//
//   Parameters:
//     M_SUPPORT      1: OP with funct7=0000001 decodes as mul/div, 0: illegal
//     ZICSR_SUPPORT  1: SYSTEM with funct3!=000 legal, 0: illegal
//     SKID           1: one-entry skid, registered o_ready; 0: no skid
//
//   Ports:
//     i_clk, i_reset        clock, synchronous active-high reset
//     i_ce / o_ready        upstream valid / stage can accept
//     i_instruction, i_pc   instruction word and address
//     i_illegal             fetch fault for this word
//     i_flush               discard all held entries
//     i_stalled             execute cannot take o_valid this cycle
//     o_valid, o_pc         decoded entry present, its PC
//     o_rs1/o_rs2/o_rd      register indices (raw fields, o_rd=0 if illegal)
//     o_funct3, o_funct7    raw funct fields
//     o_imm                 immediate (0 for R-type and illegal)
//     o_lui..o_muldiv       one-hot class (all 0 if illegal)
//     o_illegal, o_cause    illegal flag, 00 none / 01 fetch / 10 encoding
//
//   SKID=1 states:
//     state | meaning
//     EMPTY | skid empty, o_ready=1
//     FULL  | skid holds the entry behind the output register, o_ready=0
module rv_decode_stage #(
  parameter bit M_SUPPORT     = 1'b0,
  parameter bit ZICSR_SUPPORT = 1'b0,
  parameter bit SKID          = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_ce,
  output logic        o_ready,
  input  logic [31:0] i_instruction,
  input  logic [31:0] i_pc,
  input  logic        i_illegal,
  input  logic        i_flush,
  input  logic        i_stalled,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [4:0]  o_rd,
  output logic [2:0]  o_funct3,
  output logic [6:0]  o_funct7,
  output logic [31:0] o_imm,
  output logic        o_lui,
  output logic        o_auipc,
  output logic        o_jal,
  output logic        o_jalr,
  output logic        o_alu,
  output logic        o_system,
  output logic        o_fence,
  output logic        o_load,
  output logic        o_store,
  output logic        o_branch,
  output logic        o_muldiv,
  output logic        o_illegal,
  output logic [1:0]  o_cause
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // class bit positions: lui auipc jal jalr alu system fence load store branch muldiv
  localparam int C_LUI = 10, C_AUIPC = 9, C_JAL = 8, C_JALR = 7, C_ALU = 6;
  localparam int C_SYS = 5, C_FENCE = 4, C_LOAD = 3, C_STORE = 2, C_BR = 1, C_MD = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [10:0] cls;
    logic        illegal;
    logic [1:0]  cause;
  } dec_t;

  logic [31:0] inst;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] imm_raw;
  logic [10:0] cls_raw;
  logic        enc_bad;
  dec_t        dec;

  assign inst  = i_instruction;
  assign f3    = inst[14:12];
  assign f7    = inst[31:25];
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    cls_raw = '0;
    imm_raw = '0;
    enc_bad = 1'b0;
    // every valid opcode ends in 2'b11, so compressed encodings fall to default
    case (inst[6:0])
      OPC_LUI:   begin cls_raw[C_LUI] = 1'b1;   imm_raw = imm_u; end
      OPC_AUIPC: begin cls_raw[C_AUIPC] = 1'b1; imm_raw = imm_u; end
      OPC_JAL:   begin cls_raw[C_JAL] = 1'b1;   imm_raw = imm_j; end
      OPC_JALR: begin
        cls_raw[C_JALR] = 1'b1;
        imm_raw = imm_i;
        enc_bad = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        cls_raw[C_BR] = 1'b1;
        imm_raw = imm_b;
        enc_bad = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_LOAD: begin
        cls_raw[C_LOAD] = 1'b1;
        imm_raw = imm_i;
        enc_bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        cls_raw[C_STORE] = 1'b1;
        imm_raw = imm_s;
        enc_bad = (f3 >= 3'b011);
      end
      OPC_OPIMM: begin
        cls_raw[C_ALU] = 1'b1;
        imm_raw = imm_i;
        // shifts carry funct7 in the upper immediate bits
        if (f3 == 3'b001)
          enc_bad = (f7 != 7'b0000000);
        else if (f3 == 3'b101)
          enc_bad = (f7 != 7'b0000000) && (f7 != 7'b0100000);
      end
      OPC_OP: begin
        case (f7)
          7'b0000000: cls_raw[C_ALU] = 1'b1;
          7'b0100000: begin
            cls_raw[C_ALU] = 1'b1;
            enc_bad = (f3 != 3'b000) && (f3 != 3'b101);
          end
          7'b0000001: begin
            cls_raw[C_MD] = 1'b1;
            enc_bad = !M_SUPPORT;
          end
          default: enc_bad = 1'b1;
        endcase
      end
      OPC_FENCE: begin cls_raw[C_FENCE] = 1'b1; imm_raw = imm_i; end
      OPC_SYSTEM: begin
        cls_raw[C_SYS] = 1'b1;
        imm_raw = imm_i;
        enc_bad = (f3 != 3'b000) && !ZICSR_SUPPORT;
      end
      default: enc_bad = 1'b1;
    endcase
  end

  always_comb begin
    dec.pc      = i_pc;
    dec.rs1     = inst[19:15];
    dec.rs2     = inst[24:20];
    dec.funct3  = f3;
    dec.funct7  = f7;
    dec.illegal = i_illegal || enc_bad;
    dec.cause   = i_illegal ? 2'b01 : (enc_bad ? 2'b10 : 2'b00);
    dec.rd      = dec.illegal ? 5'd0 : inst[11:7];
    dec.imm     = dec.illegal ? 32'd0 : imm_raw;
    dec.cls     = dec.illegal ? 11'd0 : cls_raw;
  end

  dec_t out_q, skid_q;
  logic out_valid, skid_valid;
  logic xfer;

  // skid_valid is the FULL state flag; with SKID=0 it never sets
  assign o_ready = SKID ? !skid_valid : (!out_valid || !i_stalled);
  assign xfer    = i_ce && o_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
    end else if (i_flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (!i_stalled) begin
        out_q      <= skid_q;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end
    end else if (xfer) begin
      if (SKID && out_valid && i_stalled) begin
        skid_q     <= dec;
        skid_valid <= 1'b1;
      end else begin
        out_q     <= dec;
        out_valid <= 1'b1;
      end
    end else if (!i_stalled) begin
      out_valid <= 1'b0;
    end
  end

  assign o_valid   = out_valid;
  assign o_pc      = out_q.pc;
  assign o_rs1     = out_q.rs1;
  assign o_rs2     = out_q.rs2;
  assign o_rd      = out_q.rd;
  assign o_funct3  = out_q.funct3;
  assign o_funct7  = out_q.funct7;
  assign o_imm     = out_q.imm;
  assign o_lui     = out_q.cls[C_LUI];
  assign o_auipc   = out_q.cls[C_AUIPC];
  assign o_jal     = out_q.cls[C_JAL];
  assign o_jalr    = out_q.cls[C_JALR];
  assign o_alu     = out_q.cls[C_ALU];
  assign o_system  = out_q.cls[C_SYS];
  assign o_fence   = out_q.cls[C_FENCE];
  assign o_load    = out_q.cls[C_LOAD];
  assign o_store   = out_q.cls[C_STORE];
  assign o_branch  = out_q.cls[C_BR];
  assign o_muldiv  = out_q.cls[C_MD];
  assign o_illegal = out_q.illegal;
  assign o_cause   = out_q.cause;

endmodule

// File: tb/tb_rv_decode_stage.sv
module tb_rv_decode_stage;

  localparam logic [10:0] K_LUI = 11'h400, K_AUIPC = 11'h200, K_JAL = 11'h100;
  localparam logic [10:0] K_JALR = 11'h080, K_ALU = 11'h040, K_SYS = 11'h020;
  localparam logic [10:0] K_FENCE = 11'h010, K_LOAD = 11'h008, K_STORE = 11'h004;
  localparam logic [10:0] K_BR = 11'h002, K_MD = 11'h001, K_NONE = 11'h000;

  logic        clk = 1'b0;
  logic        reset, ce, fill, flush, stall, stall_b;
  logic [31:0] instr, pc;

  wire        ready_a, valid_a, ill_a;
  wire [31:0] pc_a, imm_a;
  wire [4:0]  rs1_a, rs2_a, rd_a;
  wire [2:0]  f3_a;
  wire [6:0]  f7_a;
  wire [10:0] cls_a;
  wire [1:0]  cause_a;

  wire        ready_b, valid_b, ill_b;
  wire [31:0] pc_b, imm_b;
  wire [4:0]  rs1_b, rs2_b, rd_b;
  wire [2:0]  f3_b;
  wire [6:0]  f7_b;
  wire [10:0] cls_b;
  wire [1:0]  cause_b;

  always #5 clk = ~clk;

  rv_decode_stage #(.M_SUPPORT(1'b0), .ZICSR_SUPPORT(1'b0), .SKID(1'b1)) dut_a (
    .i_clk(clk), .i_reset(reset), .i_ce(ce), .o_ready(ready_a),
    .i_instruction(instr), .i_pc(pc), .i_illegal(fill), .i_flush(flush),
    .i_stalled(stall), .o_valid(valid_a), .o_pc(pc_a), .o_rs1(rs1_a),
    .o_rs2(rs2_a), .o_rd(rd_a), .o_funct3(f3_a), .o_funct7(f7_a), .o_imm(imm_a),
    .o_lui(cls_a[10]), .o_auipc(cls_a[9]), .o_jal(cls_a[8]), .o_jalr(cls_a[7]),
    .o_alu(cls_a[6]), .o_system(cls_a[5]), .o_fence(cls_a[4]), .o_load(cls_a[3]),
    .o_store(cls_a[2]), .o_branch(cls_a[1]), .o_muldiv(cls_a[0]),
    .o_illegal(ill_a), .o_cause(cause_a));

  rv_decode_stage #(.M_SUPPORT(1'b1), .ZICSR_SUPPORT(1'b1), .SKID(1'b0)) dut_b (
    .i_clk(clk), .i_reset(reset), .i_ce(ce), .o_ready(ready_b),
    .i_instruction(instr), .i_pc(pc), .i_illegal(fill), .i_flush(flush),
    .i_stalled(stall_b), .o_valid(valid_b), .o_pc(pc_b), .o_rs1(rs1_b),
    .o_rs2(rs2_b), .o_rd(rd_b), .o_funct3(f3_b), .o_funct7(f7_b), .o_imm(imm_b),
    .o_lui(cls_b[10]), .o_auipc(cls_b[9]), .o_jal(cls_b[8]), .o_jalr(cls_b[7]),
    .o_alu(cls_b[6]), .o_system(cls_b[5]), .o_fence(cls_b[4]), .o_load(cls_b[3]),
    .o_store(cls_b[2]), .o_branch(cls_b[1]), .o_muldiv(cls_b[0]),
    .o_illegal(ill_b), .o_cause(cause_b));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [10:0] cls;
    logic [1:0]  cause;
  } exp_t;

  // Reference decode straight from the instruction-set rules.
  function automatic exp_t model(input logic [31:0] w, input bit fetch_bad,
                                 input bit m, input bit z);
    exp_t e;
    logic [2:0]  f3 = w[14:12];
    logic [6:0]  f7 = w[31:25];
    logic [31:0] ii, si, bi, ui, ji;
    bit ok;
    ii = 32'($signed(w) >>> 20);
    si = (ii & ~32'h1F) | 32'(w[11:7]);
    bi = (si & ~32'h801) | (32'(w[7]) << 11);
    ui = w & 32'hFFFFF000;
    ji = (32'($signed(w) >>> 11) & 32'hFFF00000) | (w & 32'h000FF000)
       | ((w >> 9) & 32'h800) | ((w >> 20) & 32'h7FE);
    e.imm = 0; e.cls = K_NONE; ok = 1;
    case (w[6:0])
      7'h37: begin e.cls = K_LUI;   e.imm = ui; end
      7'h17: begin e.cls = K_AUIPC; e.imm = ui; end
      7'h6F: begin e.cls = K_JAL;   e.imm = ji; end
      7'h67: begin e.cls = K_JALR;  e.imm = ii; ok = (f3 == 0); end
      7'h63: begin e.cls = K_BR;    e.imm = bi; ok = !(f3 inside {3'd2, 3'd3}); end
      7'h03: begin e.cls = K_LOAD;  e.imm = ii; ok = !(f3 inside {3'd3, 3'd6, 3'd7}); end
      7'h23: begin e.cls = K_STORE; e.imm = si; ok = (f3 < 3); end
      7'h13: begin
        e.cls = K_ALU; e.imm = ii;
        if (f3 == 1) ok = (f7 == 0);
        else if (f3 == 5) ok = (f7 inside {7'h00, 7'h20});
      end
      7'h33: begin
        if (f7 == 7'h01) begin e.cls = K_MD; ok = m; end
        else begin
          e.cls = K_ALU;
          ok = (f7 == 0) || (f7 == 7'h20 && f3 inside {3'd0, 3'd5});
        end
      end
      7'h0F: begin e.cls = K_FENCE; e.imm = ii; end
      7'h73: begin e.cls = K_SYS;   e.imm = ii; ok = (f3 == 0) || z; end
      default: ok = 0;
    endcase
    e.cause = fetch_bad ? 2'd1 : (ok ? 2'd0 : 2'd2);
    e.rd = w[11:7];
    if (e.cause != 0) begin e.cls = K_NONE; e.imm = 0; e.rd = 0; end
    return e;
  endfunction

  task automatic chk_a(input string t, input exp_t e, input logic [31:0] w, input logic [31:0] p);
    chk({t, " a.valid"}, 32'(valid_a), 1);
    chk({t, " a.pc"}, pc_a, p);
    chk({t, " a.rs1"}, 32'(rs1_a), 32'(w[19:15]));
    chk({t, " a.rs2"}, 32'(rs2_a), 32'(w[24:20]));
    chk({t, " a.f3f7"}, 32'({f7_a, f3_a}), 32'({w[31:25], w[14:12]}));
    chk({t, " a.rd"}, 32'(rd_a), 32'(e.rd));
    chk({t, " a.imm"}, imm_a, e.imm);
    chk({t, " a.cls"}, 32'(cls_a), 32'(e.cls));
    chk({t, " a.illegal"}, 32'(ill_a), 32'(e.cause != 0));
    chk({t, " a.cause"}, 32'(cause_a), 32'(e.cause));
  endtask

  task automatic chk_b(input string t, input exp_t e, input logic [31:0] p);
    chk({t, " b.valid"}, 32'(valid_b), 1);
    chk({t, " b.pc"}, pc_b, p);
    chk({t, " b.rd"}, 32'(rd_b), 32'(e.rd));
    chk({t, " b.imm"}, imm_b, e.imm);
    chk({t, " b.cls"}, 32'(cls_b), 32'(e.cls));
    chk({t, " b.cause"}, 32'(cause_b), 32'(e.cause));
  endtask

  typedef struct {
    logic [31:0] inst;
    bit          fbad;
    logic [4:0]  rd;
    logic [10:0] cls_a; logic [31:0] imm_a; logic [1:0] cause_a;
    logic [10:0] cls_b; logic [31:0] imm_b; logic [1:0] cause_b;
  } vec_t;

  vec_t vecs[13];

  task automatic drive(input logic [31:0] w, input logic [31:0] p, input bit c);
    instr = w; pc = p; ce = c;
  endtask

  logic [6:0] opcs[11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                           7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

  initial begin
    exp_t ea, eb;
    logic [31:0] pw, pp;
    bit pf, pc_on;

    vecs[0]  = '{32'h00500093, 0, 5'd1,  K_ALU,  32'd5,        2'd0, K_ALU, 32'd5,        2'd0};
    vecs[1]  = '{32'hFE000EE3, 0, 5'd29, K_BR,   32'hFFFFFFFC, 2'd0, K_BR,  32'hFFFFFFFC, 2'd0};
    vecs[2]  = '{32'h800000EF, 0, 5'd1,  K_JAL,  32'hFFF00000, 2'd0, K_JAL, 32'hFFF00000, 2'd0};
    vecs[3]  = '{32'h02208033, 0, 5'd0,  K_NONE, 32'd0,        2'd2, K_MD,  32'd0,        2'd0};
    vecs[4]  = '{32'h003100B3, 1, 5'd1,  K_NONE, 32'd0,        2'd1, K_NONE, 32'd0,       2'd1};
    vecs[5]  = '{32'h0000007F, 0, 5'd0,  K_NONE, 32'd0,        2'd2, K_NONE, 32'd0,       2'd2};
    vecs[6]  = '{32'h300110F3, 0, 5'd1,  K_NONE, 32'd0,        2'd2, K_SYS, 32'h300,      2'd0};
    vecs[7]  = '{32'h12345037, 0, 5'd0,  K_LUI,  32'h12345000, 2'd0, K_LUI, 32'h12345000, 2'd0};
    vecs[8]  = '{32'h40001033, 0, 5'd0,  K_NONE, 32'd0,        2'd2, K_NONE, 32'd0,       2'd2};
    vecs[9]  = '{32'h4000D093, 0, 5'd1,  K_ALU,  32'h400,      2'd0, K_ALU, 32'h400,      2'd0};
    vecs[10] = '{32'hFFC12083, 0, 5'd1,  K_LOAD, 32'hFFFFFFFC, 2'd0, K_LOAD, 32'hFFFFFFFC, 2'd0};
    vecs[11] = '{32'hFE112E23, 0, 5'd28, K_STORE, 32'hFFFFFFFC, 2'd0, K_STORE, 32'hFFFFFFFC, 2'd0};
    vecs[12] = '{32'h00000073, 0, 5'd0,  K_SYS,  32'd0,        2'd0, K_SYS, 32'd0,        2'd0};

    reset = 1; flush = 0; stall = 0; stall_b = 0; fill = 0;
    drive(32'h00000013, 32'h0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst valid", 32'(valid_a), 0);
    chk("rst ready", 32'(ready_a), 1);
    chk("rst illegal", 32'(ill_a), 0);
    chk("rst cause", 32'(cause_a), 0);
    chk("rst cls", 32'(cls_a), 0);
    chk("rst pc/imm", pc_a | imm_a, 0);
    chk("rst fields", 32'({rs1_a, rs2_a, rd_a, f3_a, f7_a}), 0);
    reset = 0;

    // directed vector table, one transfer each, no stall
    for (int i = 0; i < 13; i++) begin
      fill = vecs[i].fbad;
      drive(vecs[i].inst, 32'h1000 + 32'(i) * 4, 1);
      @(negedge clk);
      ce = 0; fill = 0;
      ea.rd = (vecs[i].cause_a != 0) ? 5'd0 : vecs[i].rd;
      ea.imm = vecs[i].imm_a; ea.cls = vecs[i].cls_a; ea.cause = vecs[i].cause_a;
      eb.rd = (vecs[i].cause_b != 0) ? 5'd0 : vecs[i].rd;
      eb.imm = vecs[i].imm_b; eb.cls = vecs[i].cls_b; eb.cause = vecs[i].cause_b;
      chk_a($sformatf("vec%0d", i), ea, vecs[i].inst, 32'h1000 + 32'(i) * 4);
      chk_b($sformatf("vec%0d", i), eb, 32'h1000 + 32'(i) * 4);
    end
    @(negedge clk);
    chk("idle valid", 32'(valid_a), 0);

    // skid: A held, B into skid, C stalled upstream, then in-order drain
    stall = 1; drive(32'h00500093, 32'hA0, 1);
    @(negedge clk);
    chk("skid A held", pc_a, 32'hA0);
    chk("skid ready empty", 32'(ready_a), 1);
    drive(32'h00500093, 32'hB0, 1);
    @(negedge clk);
    chk("skid full ready", 32'(ready_a), 0);
    chk("skid A stable", pc_a, 32'hA0);
    drive(32'h00500093, 32'hC0, 1);
    @(negedge clk);
    chk("skid C blocked ready", 32'(ready_a), 0);
    chk("skid A still", pc_a, 32'hA0);
    stall = 0;
    @(negedge clk);
    chk("drain B", pc_a, 32'hB0);
    chk("drain B valid", 32'(valid_a), 1);
    chk("drain ready", 32'(ready_a), 1);
    @(negedge clk);
    ce = 0;
    chk("drain C", pc_a, 32'hC0);
    chk("drain C valid", 32'(valid_a), 1);
    @(negedge clk);
    chk("drain done", 32'(valid_a), 0);

    // flush while FULL with an offered input
    stall = 1; drive(32'h00500093, 32'hD0, 1);
    @(negedge clk);
    drive(32'h00500093, 32'hE0, 1);
    @(negedge clk);
    chk("flush pre ready", 32'(ready_a), 0);
    flush = 1; drive(32'h00500093, 32'hF0, 1);
    @(negedge clk);
    chk("flush valid", 32'(valid_a), 0);
    chk("flush ready", 32'(ready_a), 1);
    flush = 0; ce = 0; stall = 0;
    repeat (2) begin
      @(negedge clk);
      chk("flush no ghost", 32'(valid_a), 0);
    end
    // flush with a same-cycle transfer in EMPTY
    flush = 1; drive(32'h00500093, 32'h110, 1);
    @(negedge clk);
    flush = 0; ce = 0;
    chk("flush xfer dropped", 32'(valid_a), 0);

    // SKID=0 instance: ready is combinational on valid/stall
    stall_b = 1; drive(32'h00500093, 32'h120, 1);
    @(negedge clk);
    ce = 0;
    chk("noskid held ready", 32'(ready_b), 0);
    stall_b = 0;
    #1;
    chk("noskid comb ready", 32'(ready_b), 1);
    @(negedge clk);

    // random back-to-back stream against the reference model
    pc_on = 0; pw = 0; pp = 0; pf = 0;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] w;
      int k;
      if (pc_on) begin
        chk_a("rnd", model(pw, pf, 0, 0), pw, pp);
        chk_b("rnd", model(pw, pf, 1, 1), pp);
      end else begin
        chk("rnd idle", 32'(valid_a), 0);
      end
      w = $urandom;
      k = $urandom_range(0, 12);
      if (k < 11) w[6:0] = opcs[k];
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        2: w[31:25] = 7'h01;
        default: ;
      endcase
      pw = w; pp = $urandom; pf = ($urandom_range(0, 15) == 0);
      pc_on = ($urandom_range(0, 7) != 0);
      fill = pf;
      drive(pw, pp, pc_on);
      @(negedge clk);
    end
    ce = 0; fill = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_decode_stage.md
# rv_decode_stage

Parametrised RV32I decode stage sitting between fetch and execute in the RISC-V core. It accepts one fetched instruction per cycle, classifies it, extracts register indices and the sign-extended immediate, and flags illegal encodings. It registers its result behind a valid/stall handshake with optional M-extension and Zicsr decode, plus an optional skid entry so upstream ready is a flop.

## Interface
- M_SUPPORT, 0: 1 = decode OP funct7=0000001 as mul/div (o_muldiv); 0 = such encodings illegal.
- ZICSR_SUPPORT, 0: 1 = SYSTEM with funct3≠000 legal (CSR ops); 0 = illegal.
- SKID, 1: 1 = one-entry skid buffer, o_ready registered; 0 = no skid, o_ready combinational.

- Clock and reset: one clock; reset is synchronous and active-high.
- i_clk  in  1  clock.
- i_reset  in  1  synchronous active-high reset.
- i_ce  in  1  upstream instruction valid.
- o_ready  out  1  stage can accept; a transfer occurs when i_ce && o_ready.
- i_instruction  in  32  instruction word.
- i_pc  in  32  instruction address.
- i_illegal  in  1  fetch fault for this word.
- i_flush  in  1  discard all held entries (branch/trap redirect).
- i_stalled  in  1  execute cannot take o_valid this cycle.
- o_valid  out  1  decoded entry present.
- o_pc  out  32  PC of entry.
- o_rs1, o_rs2, o_rd  out  5 each  register indices.
- o_funct3  out  3; o_funct7  out  7.
- o_imm  out  32  sign-extended immediate per format.
- o_lui, o_auipc, o_jal, o_jalr, o_alu, o_system, o_fence, o_load, o_store, o_branch, o_muldiv  out  1 each  one-hot class.
- o_illegal  out  1; o_cause  out  2  (00 none, 01 fetch fault, 10 illegal encoding).

## Operation
- Decode combinational on i_instruction; result captured into output register (or skid) on transfer.
- Immediates: I = inst[31:20]; S = {inst[31:25],inst[11:7]}; B = {inst[31],inst[7],inst[30:25],inst[11:8],0}; U = {inst[31:12],12'b0}; J = {inst[31],inst[19:12],inst[20],inst[30:21],0}; all sign-extended from bit 31. o_alu covers OP and OP-IMM (I-imm); R-type and illegal give o_imm=0.
- Illegal encoding: inst[1:0]≠11; unknown opcode; JALR funct3≠000; branch funct3 010/011; load funct3 011/110/111; store funct3 ≥011; OP funct7 other than 0000000, 0100000 (only with funct3 000/101), 0000001 (only if M_SUPPORT); OP-IMM shifts with funct7 other than 0000000/0100000 (0100000 only funct3 101); SYSTEM per ZICSR_SUPPORT.
- Priority: i_illegal → cause 01, else encoding error → cause 10. On any illegal: o_illegal=1, all class flags 0, o_rd=0, o_pc still valid.
- SKID=1 states: EMPTY (o_ready=1, skid empty) and FULL (o_ready=0). Transfer while output held (o_valid && i_stalled) → entry to skid, go FULL. In FULL, when i_stalled=0 the skid moves to output, go EMPTY. Output register otherwise loads on transfer when (!o_valid || !i_stalled).
- SKID=0: o_ready = !o_valid || !i_stalled.
- Ordering: entries leave strictly in acceptance order.

## Timing
- Latency 1 cycle: transfer at edge N → o_valid at N+1.
- Throughput 1/cycle with i_stalled=0.
- Output fields stable while o_valid && i_stalled.
- Reset: o_valid=0, skid empty, o_ready=1 (SKID=1), o_illegal=0, o_cause=00, all class flags 0, o_pc/o_imm/indices/funct 0.
- i_flush: next cycle o_valid=0, skid empty, o_ready=1; a same-cycle transfer is discarded. i_reset overrides i_flush.
- Simultaneous FULL drain and new i_ce: o_ready=0, so input not taken that cycle.

## Test plan
- Reset then 0x00500093 (addi x1,x0,5), i_stalled=0 → next cycle o_valid=1, o_alu=1, o_rd=1, o_rs1=0, o_imm=5, o_illegal=0.
- 0xFE000EE3 (beq x0,x0,-4) → o_branch=1, o_imm=0xFFFFFFFC; 0x800000EF (jal x1) → o_jal=1, o_imm=0xFFF00000.
- 0x02208033 (mul) with M_SUPPORT=0 → o_illegal=1, o_cause=10, flags 0; M_SUPPORT=1 → o_muldiv=1.
- Fetch with i_illegal=1 on valid add → o_cause=01; 0x0000007F → o_cause=10.
- SKID=1: hold i_stalled=1 over 3 back-to-back inputs A,B,C → A held, B in skid, o_ready=0, C stalled upstream; release → A,B,C emerge in order, no loss or duplicate.
- Assert i_flush while FULL with i_ce=1 → next cycle o_valid=0, o_ready=1, discarded input never appears.
